// File: rtl/tinker_pkg.sv
// ----------------------------------------------------------------------------
// tinker_pkg: run-state encoding and default parameters for the tinker run controller.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tinker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } run_state_e;

  localparam int DEF_NUM_CORES      = 1;
  localparam int DEF_RESET_CYCLES   = 2;
  localparam int DEF_TIMEOUT_CYCLES = 100;
  localparam int DEF_CNT_W          = 32;

endpackage

`default_nettype wire

// File: rtl/tinker_halt_capture.sv
// ----------------------------------------------------------------------------
// tinker_halt_capture: latches the first hlt of one core and the cycle it came.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tinker_halt_capture #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             capture_en,
  input  logic             hlt,
  input  logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic [CNT_W-1:0] halt_cycle
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted     <= 1'b0;
      halt_cycle <= '0;
    end else if (clear) begin
      halted     <= 1'b0;
      halt_cycle <= '0;
    end else if (capture_en && hlt && !halted) begin
      halted     <= 1'b1;
      halt_cycle <= cycle_count;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tinker_run_ctrl.sv
// ----------------------------------------------------------------------------
// tinker_run_ctrl: holds cores in reset, runs them until all halt or timeout.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tinker_run_ctrl
  import tinker_pkg::*;
#(
  parameter int NUM_CORES      = DEF_NUM_CORES,
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_CORES-1:0]       core_hlt,
  output logic [NUM_CORES-1:0]       core_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       timed_out,
  output logic [NUM_CORES-1:0]       halted_mask,
  output logic [CNT_W-1:0]           cycle_count,
  output logic [NUM_CORES*CNT_W-1:0] halt_cycle
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);

  generate
    if (NUM_CORES < 1 || NUM_CORES > 8) begin : g_bad_num_cores
      $error("NUM_CORES must be in 1..8");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
      $error("RESET_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_min
      $error("TIMEOUT_CYCLES must be at least 2");
    end
    if (CNT_W < 63 && (longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_timeout_width
      $error("TIMEOUT_CYCLES must be below 2**CNT_W");
    end
  endgenerate

  run_state_e        state;
  run_state_e        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              enter_hold;
  logic              run_end;
  logic              timeout_end;
  logic              capture_en;
  logic              all_halted;
  logic              at_timeout;

  // Includes this cycle's captures so the final halt beats a same-cycle timeout.
  assign all_halted = &(halted_mask | core_hlt);
  assign at_timeout = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));
  assign capture_en = (state == ST_RUN) && !abort;

  always_comb begin
    state_nxt   = state;
    busy        = 1'b0;
    core_reset  = '1;
    enter_hold  = 1'b0;
    run_end     = 1'b0;
    timeout_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          state_nxt  = ST_RESET_HOLD;
          enter_hold = 1'b1;
        end
      end
      ST_RESET_HOLD: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (hold_cnt == '0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy       = 1'b1;
        core_reset = halted_mask;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (all_halted) begin
          state_nxt = ST_DONE;
          run_end   = 1'b1;
        end else if (at_timeout) begin
          state_nxt   = ST_DONE;
          run_end     = 1'b1;
          timeout_end = 1'b1;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt  = ST_RESET_HOLD;
          enter_hold = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      cycle_count <= '0;
      timed_out   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= run_end;
      if (enter_hold) begin
        hold_cnt <= HOLD_W'(RESET_CYCLES - 1);
      end else if (state == ST_RESET_HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
      // Count only while staying in RUN so the final value is the last RUN cycle.
      if (enter_hold) begin
        cycle_count <= '0;
      end else if (state == ST_RUN && state_nxt == ST_RUN) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (enter_hold) begin
        timed_out <= 1'b0;
      end else if (timeout_end) begin
        timed_out <= 1'b1;
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      tinker_halt_capture #(
        .CNT_W (CNT_W)
      ) u_capture (
        .clk         (clk),
        .reset       (reset),
        .clear       (enter_hold),
        .capture_en  (capture_en),
        .hlt         (core_hlt[i]),
        .cycle_count (cycle_count),
        .halted      (halted_mask[i]),
        .halt_cycle  (halt_cycle[i*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_tinker_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tinker_run_ctrl: scoreboard bench for a 3-core run controller.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tinker_run_ctrl;

  localparam int NC      = 3;
  localparam int RST_CYC = 2;
  localparam int TMO     = 100;
  localparam int CW      = 32;

  typedef struct packed {
    logic           to;
    logic [NC-1:0]  mask;
    logic [CW-1:0]  cnt;
    logic [NC*CW-1:0] hc;
  } res_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [NC-1:0]     core_hlt = '0;
  logic [NC-1:0]     core_reset;
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [NC-1:0]     halted_mask;
  logic [CW-1:0]     cycle_count;
  logic [NC*CW-1:0]  halt_cycle;

  int checks = 0;
  int errors = 0;
  res_t sb[$];

  tinker_run_ctrl #(
    .NUM_CORES      (NC),
    .RESET_CYCLES   (RST_CYC),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .core_hlt    (core_hlt),
    .core_reset  (core_reset),
    .busy        (busy),
    .done        (done),
    .timed_out   (timed_out),
    .halted_mask (halted_mask),
    .cycle_count (cycle_count),
    .halt_cycle  (halt_cycle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // h*: RUN cycle at which each core raises hlt (-1 = never); abort_at/start_at: RUN cycle or -1.
  task automatic run_case(input int h0, input int h1, input int h2,
                          input int abort_at, input int start_at);
    int h [NC];
    int end_k;
    bit all_in;
    bit finished;
    res_t e;
    res_t r;
    logic [NC-1:0] exp_rst;
    logic [NC-1:0] ab_mask;
    h[0] = h0; h[1] = h1; h[2] = h2;
    all_in = 1'b1;
    end_k  = 0;
    for (int i = 0; i < NC; i++) begin
      if (h[i] < 0 || h[i] > TMO - 1) all_in = 1'b0;
      else if (h[i] > end_k) end_k = h[i];
    end
    if (!all_in) end_k = TMO - 1;
    e.to   = !all_in;
    e.cnt  = CW'(end_k);
    e.mask = '0;
    e.hc   = '0;
    for (int i = 0; i < NC; i++) begin
      if (h[i] >= 0 && h[i] <= end_k) begin
        e.mask[i]       = 1'b1;
        e.hc[i*CW +: CW] = CW'(h[i]);
      end
    end
    if (abort_at < 0) sb.push_back(e);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_busy", busy, 1);
    check("hold_rst", core_reset, 3'b111);
    check("clr_cnt", cycle_count, 0);
    check("clr_mask", halted_mask, 0);
    check("clr_hc", halt_cycle, 0);
    check("clr_to", timed_out, 0);
    tick();
    check("hold2_busy", busy, 1);
    check("hold2_rst", core_reset, 3'b111);
    tick();

    finished = 1'b0;
    for (int k = 0; k < TMO + 20 && !finished; k++) begin
      exp_rst = '0;
      for (int i = 0; i < NC; i++) begin
        exp_rst[i]  = (h[i] >= 0 && h[i] < k);
        core_hlt[i] = (h[i] >= 0 && k >= h[i]);
      end
      check("run_rst", core_reset, exp_rst);
      check("run_cnt", cycle_count, k);
      check("run_busy", busy, 1);
      abort = (k == abort_at);
      start = (k == start_at);
      tick();
      abort = 1'b0;
      start = 1'b0;
      if (k == abort_at) begin
        finished = 1'b1;
        ab_mask = '0;
        for (int i = 0; i < NC; i++) ab_mask[i] = (h[i] >= 0 && h[i] < k);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rst", core_reset, 3'b111);
        check("abort_cnt", cycle_count, k);
        check("abort_mask", halted_mask, ab_mask);
        check("abort_to", timed_out, 0);
        core_hlt = '0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check("abort_nodone", done, 0);
          check("abort_idle", busy, 0);
        end
      end else if (done) begin
        finished = 1'b1;
        check("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          r = sb.pop_front();
          check("res_to", timed_out, r.to);
          check("res_mask", halted_mask, r.mask);
          check("res_cnt", cycle_count, r.cnt);
          check("res_hc", halt_cycle, r.hc);
        end
        check("end_cycle", k, end_k);
        check("done_busy", busy, 0);
        check("done_rst", core_reset, 3'b111);
        core_hlt = '0;
        tick();
        check("done_pulse", done, 0);
        check("done_held_cnt", cycle_count, e.cnt);
        check("done_held_mask", halted_mask, e.mask);
      end
    end
    if (!finished) check("done_seen", 0, 1);
    core_hlt = '0;
  endtask

  task automatic reset_mid_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      core_hlt[0] = (k >= 2);
      tick();
    end
    check("pre_rst_mask", halted_mask, 3'b001);
    #2 reset = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rst", core_reset, 3'b111);
    check("rst_mask", halted_mask, 0);
    check("rst_cnt", cycle_count, 0);
    check("rst_hc", halt_cycle, 0);
    check("rst_to", timed_out, 0);
    core_hlt = '0;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_creset", core_reset, 3'b111);
  endtask

  initial begin
    #1;
    check("init_rst", core_reset, 3'b111);
    check("init_busy", busy, 0);
    check("init_done", done, 0);
    check("init_to", timed_out, 0);
    check("init_mask", halted_mask, 0);
    check("init_cnt", cycle_count, 0);
    check("init_hc", halt_cycle, 0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    run_case(10, 10, 10, -1, -1);

    // start with abort in DONE returns to IDLE and freezes results
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    tick();
    check("sa_idle", busy, 0);
    check("sa_cnt", cycle_count, 10);

    run_case(5, 20, 12, -1, -1);
    run_case(-1, -1, -1, -1, -1);
    run_case(30, 99, 50, -1, -1);
    run_case(40, -1, 120, -1, -1);
    run_case(3, -1, -1, 7, -1);
    run_case(2, 4, 6, -1, 3);
    reset_mid_run();
    run_case(1, 8, 15, -1, -1);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/tinker_run_ctrl.md
TINKER_RUN_CTRL -- requirements
Module: tinker_run_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_CORES, 1, number of tinker_core instances controlled (1..8).
- RESET_CYCLES, 2, clk cycles core reset is held per run (>=1).
- TIMEOUT_CYCLES, 100, maximum RUN cycles before forced completion (>=2).
- CNT_W, 32, cycle counter width.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-high.
- start, in, 1: begin a run (level sampled per cycle).
- abort, in, 1: cancel the current run.
- core_hlt, in, NUM_CORES: hlt output of each core.
- core_reset, out, NUM_CORES: reset to each core; active-high.
- busy, out, 1: high in RESET_HOLD and RUN.
- done, out, 1: one-cycle pulse on run completion.
- timed_out, out, 1: last run ended by timeout.
- halted_mask, out, NUM_CORES: cores halted in the current or last run.
- cycle_count, out, CNT_W: RUN cycles elapsed.
- halt_cycle, out, NUM_CORES*CNT_W: per-core cycle_count captured at halt; core i occupies bits [i*CNT_W +: CNT_W].

Function
REQ-003 FSM states SHALL be IDLE, RESET_HOLD, RUN, DONE.
REQ-004 IDLE: core_reset all 1; busy 0; start=1 -> RESET_HOLD next edge.
REQ-005 Entry to RESET_HOLD SHALL clear cycle_count, halted_mask, halt_cycle and timed_out, and load the hold counter.
REQ-006 RESET_HOLD SHALL keep core_reset all 1 for exactly RESET_CYCLES cycles, then enter RUN; core_hlt is ignored.
REQ-007 In RUN, core_reset[i] SHALL be 0 while halted_mask[i]=0 and 1 once halted_mask[i]=1 (frozen core).
REQ-008 cycle_count SHALL be 0 in the first RUN cycle and increment by 1 each RUN cycle; it holds in all other states.
REQ-009 In RUN, core_hlt[i]=1 with halted_mask[i]=0 SHALL set halted_mask[i] and capture the current cycle_count into halt_cycle[i] at that edge; later hlt assertions are ignored.
REQ-010 In RUN, if halted_mask including this cycle's captures equals all ones, the FSM SHALL go to DONE, pulse done and leave timed_out=0.
REQ-011 In RUN, if cycle_count==TIMEOUT_CYCLES-1 and not all cores are halted, the FSM SHALL go to DONE, pulse done and set timed_out=1.
REQ-012 If the final halt and the timeout occur in the same cycle, halt SHALL win: timed_out=0.
REQ-013 DONE: core_reset all 1; results held; done=1 only in the first DONE cycle; start=1 -> RESET_HOLD (new run).
REQ-014 start SHALL be ignored while busy=1.
REQ-015 abort=1 in RESET_HOLD or RUN SHALL go to IDLE next edge with core_reset all 1 and no done pulse; results freeze. Abort outranks halt and timeout in the same cycle.
REQ-016 start and abort both high in IDLE or DONE: abort wins; the state stays or returns to IDLE.
REQ-017 Counters SHALL not wrap; the timeout terminates RUN before CNT_W overflow. An elaboration check SHALL require TIMEOUT_CYCLES < 2**CNT_W.

Reset
REQ-018 Asynchronous reset SHALL force IDLE with these values: core_reset all 1, busy 0, done 0, timed_out 0, halted_mask 0, cycle_count 0, halt_cycle 0.
REQ-019 Reset asserted mid-run SHALL abandon the run immediately with no done pulse; after release the FSM waits in IDLE for start.

Structure
REQ-020 The shared package tinker_pkg SHALL hold the run-state enum and the default parameter constants.
REQ-021 The per-core halt latch/capture SHALL be one sub-module, tinker_halt_capture, instantiated NUM_CORES times by a generate loop.

Verification
REQ-022 NUM_CORES=1, RESET_CYCLES=2, TIMEOUT_CYCLES=100; start; hlt at RUN cycle 10 -> core_reset low for RUN cycles 0..10; done pulse; halt_cycle[0]=10; timed_out=0.
REQ-023 NUM_CORES=3; cores halt at cycles 5, 20, 12 -> halted_mask rises 001, 101, 111; done only after cycle 20; halt_cycle={12,20,5}; each halted core's reset reasserts.
REQ-024 No hlt, TIMEOUT_CYCLES=100 -> done with timed_out=1 and cycle_count=99; halted_mask=0.
REQ-025 Last hlt exactly at cycle 99 -> timed_out=0 and halted_mask all ones.
REQ-026 abort at RUN cycle 7 -> IDLE, no done, core_reset all 1; then start -> counters cleared and a fresh RESET_HOLD of 2 cycles.
REQ-027 Reset pulsed mid-RUN -> IDLE immediately, all outputs at reset values; start while busy -> no effect.
